// File: rtl/encryption_controller_if.sv
// Handshake and datapath-control bundle between the AES-128 encryption
// sequencer (slave side) and the datapath / key schedule (master side).
interface encryption_controller_if;
    logic         encrypt_enable;
    logic         key_ready;
    logic [127:0] data_in;
    logic [127:0] round_data;
    logic         sub_bytes_enable;
    logic         shift_rows_enable;
    logic         mix_cols_enable;
    logic         key_addition_enable;
    logic         load_state;
    logic [127:0] plaintext_out;
    logic [3:0]   round_key_sel;
    logic         key_expand_start;
    logic         busy;
    logic         done;
    logic         error;
    logic [127:0] encrypted_output;

    modport slave (
        input  encrypt_enable, key_ready, data_in, round_data,
        output sub_bytes_enable, shift_rows_enable, mix_cols_enable,
               key_addition_enable, load_state, plaintext_out, round_key_sel,
               key_expand_start, busy, done, error, encrypted_output
    );

    modport master (
        output encrypt_enable, key_ready, data_in, round_data,
        input  sub_bytes_enable, shift_rows_enable, mix_cols_enable,
               key_addition_enable, load_state, plaintext_out, round_key_sel,
               key_expand_start, busy, done, error, encrypted_output
    );
endinterface

// File: rtl/encryption_controller.sv
// AES-128 encryption sequencer: key handshake, initial key addition, nine full
// rounds, final round without MixColumns, then ciphertext capture and done pulse.
module encryption_controller #(
    parameter int unsigned KEY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   n_rst,
    encryption_controller_if.slave ctrl
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_KEY_WAIT = 4'd1;
    localparam logic [3:0] S_LOAD     = 4'd2;
    localparam logic [3:0] S_INIT     = 4'd3;
    localparam logic [3:0] S_ROUND    = 4'd4;
    localparam logic [3:0] S_FINAL    = 4'd5;
    localparam logic [3:0] S_CAPTURE  = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ERROR    = 4'd8;

    localparam logic [3:0] LP_TIMEOUT    = 4'(KEY_TIMEOUT);
    localparam logic [3:0] LP_LAST_ROUND = 4'd9;
    localparam logic [3:0] LP_FINAL_KEY  = 4'd10;

    logic [3:0]   r_state, r_round, r_timeout;
    logic [3:0]   w_next_state, w_next_round, w_next_timeout;
    logic [127:0] r_plaintext, r_ciphertext;
    logic         r_sub, r_shift, r_mix, r_add, r_load, r_kes, r_busy, r_done, r_error;
    logic [3:0]   r_key_sel;
    logic         w_sub, w_shift, w_mix, w_add, w_load, w_kes, w_busy, w_done, w_error;
    logic [3:0]   w_key_sel;

    // Next-state, round counter and key-timeout counter.
    always_comb begin
        w_next_state   = r_state;
        w_next_round   = r_round;
        w_next_timeout = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (ctrl.encrypt_enable) begin
                    w_next_state   = S_KEY_WAIT;
                    w_next_round   = 4'd0;
                    w_next_timeout = 4'd0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_KEY_WAIT: begin
                if (ctrl.key_ready) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_timeout = r_timeout + 4'd1;
                    if (w_next_timeout >= LP_TIMEOUT) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_next_state = S_KEY_WAIT;
                    end
                end
            end
            S_LOAD:  w_next_state = S_INIT;
            S_INIT: begin
                w_next_state = S_ROUND;
                w_next_round = 4'd1;
            end
            S_ROUND: begin
                // Clamp at the final key index so the counter can never run past 10.
                if (r_round >= LP_LAST_ROUND) begin
                    w_next_state = S_FINAL;
                    w_next_round = LP_FINAL_KEY;
                end else begin
                    w_next_state = S_ROUND;
                    w_next_round = r_round + 4'd1;
                end
            end
            S_FINAL:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            S_ERROR:   w_next_state = S_IDLE;
            default: begin
                w_next_state   = S_IDLE;
                w_next_round   = 4'd0;
                w_next_timeout = 4'd0;
            end
        endcase
    end

    // Output decode of the upcoming state, so registered outputs line up with it.
    always_comb begin
        w_sub     = 1'b0;
        w_shift   = 1'b0;
        w_mix     = 1'b0;
        w_add     = 1'b0;
        w_load    = 1'b0;
        w_kes     = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_error   = 1'b0;
        w_key_sel = 4'd0;
        case (w_next_state)
            S_IDLE: w_busy = 1'b0;
            S_KEY_WAIT: begin
                w_busy = 1'b1;
                w_kes  = (r_state == S_IDLE);
            end
            S_LOAD: begin
                w_busy = 1'b1;
                w_load = 1'b1;
            end
            S_INIT: begin
                w_busy = 1'b1;
                w_add  = 1'b1;
            end
            S_ROUND: begin
                w_busy    = 1'b1;
                w_sub     = 1'b1;
                w_shift   = 1'b1;
                w_mix     = 1'b1;
                w_add     = 1'b1;
                w_key_sel = w_next_round;
            end
            S_FINAL: begin
                w_busy    = 1'b1;
                w_sub     = 1'b1;
                w_shift   = 1'b1;
                w_add     = 1'b1;
                w_key_sel = LP_FINAL_KEY;
            end
            S_CAPTURE: w_busy = 1'b1;
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            S_ERROR: begin
                w_busy  = 1'b1;
                w_error = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // State, counters, plaintext/ciphertext holding registers and outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_round      <= 4'd0;
            r_timeout    <= 4'd0;
            r_plaintext  <= 128'd0;
            r_ciphertext <= 128'd0;
            r_sub        <= 1'b0;
            r_shift      <= 1'b0;
            r_mix        <= 1'b0;
            r_add        <= 1'b0;
            r_load       <= 1'b0;
            r_kes        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_key_sel    <= 4'd0;
        end else begin
            r_state   <= w_next_state;
            r_round   <= w_next_round;
            r_timeout <= w_next_timeout;
            if ((r_state == S_IDLE) && ctrl.encrypt_enable) begin
                r_plaintext <= ctrl.data_in;
            end else begin
                r_plaintext <= r_plaintext;
            end
            if (r_state == S_CAPTURE) begin
                r_ciphertext <= ctrl.round_data;
            end else begin
                r_ciphertext <= r_ciphertext;
            end
            r_sub     <= w_sub;
            r_shift   <= w_shift;
            r_mix     <= w_mix;
            r_add     <= w_add;
            r_load    <= w_load;
            r_kes     <= w_kes;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_error   <= w_error;
            r_key_sel <= w_key_sel;
        end
    end

    assign ctrl.sub_bytes_enable    = r_sub;
    assign ctrl.shift_rows_enable   = r_shift;
    assign ctrl.mix_cols_enable     = r_mix;
    assign ctrl.key_addition_enable = r_add;
    assign ctrl.load_state          = r_load;
    assign ctrl.plaintext_out       = r_plaintext;
    assign ctrl.round_key_sel       = r_key_sel;
    assign ctrl.key_expand_start    = r_kes;
    assign ctrl.busy                = r_busy;
    assign ctrl.done                = r_done;
    assign ctrl.error               = r_error;
    assign ctrl.encrypted_output    = r_ciphertext;
endmodule

// File: tb/tb_encryption_controller.sv
// Bench for encryption_controller: couples it to a behavioural AES-128 datapath
// and key schedule, and checks latency, sequencing and ciphertext against known vectors.
module tb_encryption_controller;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    encryption_controller_if bus ();
    encryption_controller #(.KEY_TIMEOUT(15)) dut (.clk(clk), .n_rst(n_rst), .ctrl(bus));

    int n_checks = 0;
    int n_err    = 0;

    logic [127:0] sbox_row [16];
    logic [127:0] rk [16];
    logic [127:0] dp_state, dp_next;
    logic [12:0]  ctl_v;

    assign ctl_v = {bus.sub_bytes_enable, bus.shift_rows_enable, bus.mix_cols_enable,
                    bus.key_addition_enable, bus.load_state, bus.key_expand_start,
                    bus.busy, bus.done, bus.error, bus.round_key_sel};

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_row[x[7:4]];
        return row[(15 - int'(x[3:0])) * 8 +: 8];
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[(15 - i) * 8 +: 8];
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[(15 - i) * 8 +: 8] = sb(gb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[(15 - (r + 4 * c)) * 8 +: 8] = gb(s, r + 4 * ((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4 * c); a1 = gb(s, 4 * c + 1); a2 = gb(s, 4 * c + 2); a3 = gb(s, 4 * c + 3);
            o[(15 - 4 * c) * 8 +: 8]       = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
            o[(15 - 4 * c - 1) * 8 +: 8]   = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
            o[(15 - 4 * c - 2) * 8 +: 8]   = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
            o[(15 - 4 * c - 3) * 8 +: 8]   = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int i);
        case (i)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[(3 - i) * 32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0)
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon(i / 4), 24'h000000};
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = 128'd0;
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Behavioural datapath driven by the controller's enables.
    always_comb begin
        dp_next = dp_state;
        if (bus.load_state) dp_next = bus.plaintext_out;
        else begin
            if (bus.sub_bytes_enable)    dp_next = sub_bytes(dp_next);
            if (bus.shift_rows_enable)   dp_next = shift_rows(dp_next);
            if (bus.mix_cols_enable)     dp_next = mix_cols(dp_next);
            if (bus.key_addition_enable) dp_next = dp_next ^ rk[bus.round_key_sel];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) dp_state <= 128'd0;
        else        dp_state <= dp_next;
    end
    assign bus.round_data = dp_state;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        int           key_delay;   // 0: key_ready already high; >=100: never
        bit           reissue;
        bit           exp_err;
        int           exp_cycle;
        logic [127:0] exp_ct;
    } vec_t;
    vec_t vecs [6];

    task automatic run_op(input vec_t v, input string name);
        int cyc, end_cyc, kes_cnt, ka_idx, kr_on;
        bit seq_ok, bad_pulse;
        expand_key(v.key);
        kr_on = (v.key_delay == 0) ? 1 : v.key_delay;
        bus.key_ready = (v.key_delay == 0);
        bus.data_in = v.pt;
        bus.encrypt_enable = 1'b1;
        @(posedge clk); #1;
        bus.encrypt_enable = 1'b0;
        bus.data_in = ~v.pt;
        check({name, "_pt_latch"}, bus.plaintext_out, v.pt);
        cyc = 1; end_cyc = 0; kes_cnt = 0; ka_idx = 0; seq_ok = 1'b1; bad_pulse = 1'b0;
        while (cyc <= 40 && end_cyc == 0) begin
            if (bus.key_expand_start) kes_cnt++;
            if (bus.key_addition_enable) begin
                if (bus.round_key_sel != 4'(ka_idx) ||
                    bus.mix_cols_enable != (ka_idx >= 1 && ka_idx <= 9)) seq_ok = 1'b0;
                ka_idx++;
            end else if (bus.sub_bytes_enable || bus.shift_rows_enable ||
                         bus.mix_cols_enable || bus.round_key_sel != 4'd0) begin
                seq_ok = 1'b0;
            end
            if (v.exp_err ? bus.done : bus.error) bad_pulse = 1'b1;
            if (v.exp_err ? bus.error : bus.done) end_cyc = cyc;
            if (v.key_delay > 0 && cyc == v.key_delay) bus.key_ready = 1'b1;
            else if (cyc == kr_on + 1) bus.key_ready = 1'b0;
            if (v.reissue && (cyc == 3 || cyc == 10)) bus.encrypt_enable = 1'b1;
            else bus.encrypt_enable = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 128'(end_cyc), 128'(v.exp_cycle));
        check({name, "_kes_pulses"}, 128'(kes_cnt), 128'd1);
        check({name, "_rk_seq"}, {127'd0, seq_ok}, 128'd1);
        check({name, "_keyadd_count"}, 128'(ka_idx), v.exp_err ? 128'd0 : 128'd11);
        check({name, "_wrong_pulse"}, {127'd0, bad_pulse}, 128'd0);
        check({name, "_busy_after"}, {127'd0, bus.busy}, 128'd0);
        check({name, "_ciphertext"}, bus.encrypted_output, v.exp_ct);
        check({name, "_pt_held"}, bus.plaintext_out, v.pt);
    endtask

    initial begin
        bit quiet;
        bit found;
        sbox_row[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sbox_row[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sbox_row[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sbox_row[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sbox_row[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sbox_row[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sbox_row[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sbox_row[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sbox_row[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sbox_row[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sbox_row[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sbox_row[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sbox_row[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sbox_row[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sbox_row[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sbox_row[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    0, 1'b0, 1'b0, 15, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    5, 1'b0, 1'b0, 19, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    1000, 1'b0, 1'b1, 16, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    0, 1'b1, 1'b0, 15, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[4] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    0, 1'b0, 1'b0, 15, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[5] = '{128'h0, 128'h0, 0, 1'b0, 1'b0, 15, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        bus.encrypt_enable = 1'b0;
        bus.key_ready = 1'b0;
        bus.data_in = 128'd0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check("reset_ctl", 128'(ctl_v), 128'd0);
        check("reset_ct", bus.encrypted_output, 128'd0);
        check("reset_pt", bus.plaintext_out, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ctl_v != 13'd0 || bus.encrypted_output != 128'd0) quiet = 1'b0;
        end
        check("idle_quiet", {127'd0, quiet}, 128'd1);

        for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of round 5, then a clean re-run.
        expand_key(vecs[0].key);
        bus.key_ready = 1'b1;
        bus.data_in = vecs[0].pt;
        bus.encrypt_enable = 1'b1;
        @(posedge clk); #1;
        bus.encrypt_enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.mix_cols_enable && bus.round_key_sel == 4'd5) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_round5_reached", {127'd0, found}, 128'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_mid_ctl", 128'(ctl_v), 128'd0);
        check("rst_mid_ct", bus.encrypted_output, 128'd0);
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.error || bus.busy) quiet = 1'b0;
        end
        @(negedge clk) n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.error || bus.busy) quiet = 1'b0;
        end
        check("rst_no_done", {127'd0, quiet}, 128'd1);
        run_op(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
